// File: rtl/bitstream_reader_pkg.sv
// Shared JPEG entropy-stream constants and the byte-unstuffer state type,
// used by both the decoder-side reader and the encoder side.
package bitstream_reader_pkg;

    // Default bit-buffer width shared by encoder and decoder
    localparam int JPEG_BUF_W = 64;

    // Marker-related byte codes
    localparam logic [7:0] M_FF    = 8'hFF;
    localparam logic [7:0] M_STUFF = 8'h00;
    localparam logic [7:0] M_EOI   = 8'hD9;
    localparam logic [7:0] M_RST0  = 8'hD0;
    localparam logic [7:0] M_RST1  = 8'hD1;
    localparam logic [7:0] M_RST2  = 8'hD2;
    localparam logic [7:0] M_RST3  = 8'hD3;
    localparam logic [7:0] M_RST4  = 8'hD4;
    localparam logic [7:0] M_RST5  = 8'hD5;
    localparam logic [7:0] M_RST6  = 8'hD6;
    localparam logic [7:0] M_RST7  = 8'hD7;

    // Byte-level unstuffing states
    typedef enum logic [1:0] {
        US_NORMAL = 2'd0,
        US_GOT_FF = 2'd1,
        US_MARKER = 2'd2
    } us_state_e;

endpackage

// File: rtl/bitstream_reader_unstuffer.sv
// Byte unstuffer: removes FF00 stuffing and FF fill bytes, detects markers
// and holds one unstuffed byte in a pending register for the bit buffer.
module bs_unstuffer
    import bitstream_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid_i,
    input  logic [7:0] data_i,
    input  logic       marker_ack_i,
    input  logic       room_i,
    output logic       data_ready_o,
    output logic       pend_valid_o,
    output logic [7:0] pend_byte_o,
    output logic       marker_valid_o,
    output logic [7:0] marker_o
);

    us_state_e  state_q, state_d;
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] marker_q, marker_d;
    logic       ready_en_q;
    logic       accept;

    assign accept = data_valid_i & data_ready_o;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            state_q <= US_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pending/marker capture decisions per accepted byte
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d      = state_q;
        pend_valid_d = 1'b0;
        pend_d       = pend_q;
        marker_d     = marker_q;
        unique case (state_q)
            US_NORMAL: begin
                if (accept) begin
                    if (data_i == M_FF) begin
                        state_d = US_GOT_FF;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_d       = data_i;
                    end
                end
            end
            US_GOT_FF: begin
                if (accept) begin
                    if (data_i == M_STUFF) begin
                        pend_valid_d = 1'b1;
                        pend_d       = M_FF;
                        state_d      = US_NORMAL;
                    end else if (data_i != M_FF) begin
                        // FF FF is fill and stays here; anything else is a marker
                        marker_d = data_i;
                        state_d  = US_MARKER;
                    end
                end
            end
            US_MARKER: begin
                if (marker_ack_i) begin
                    state_d = US_NORMAL;
                end
            end
            default: state_d = US_NORMAL;
        endcase
    end

    // Outputs derived from registered state and buffer headroom only
    always_comb begin
        data_ready_o   = ready_en_q & (state_q != US_MARKER) & room_i;
        marker_valid_o = (state_q == US_MARKER);
    end

    // Pending byte, marker code and post-reset ready enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_q       <= 8'h00;
            marker_q     <= 8'h00;
            ready_en_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            marker_q     <= marker_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_byte_o  = pend_q;
    assign marker_o     = marker_q;

endmodule

// File: rtl/bitstream_reader.sv
// JPEG entropy bitstream reader: unstuffed bytes are appended to an MSB-first
// bit buffer; the consumer peeks 32 bits and drops 1..MAX_CONS bits per cycle.
module bitstream_reader
    import bitstream_reader_pkg::*;
#(
    parameter int BUF_W    = JPEG_BUF_W,
    parameter int MAX_CONS = 16,
    localparam int LEN_W   = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid_i,
    input  logic [7:0]       data_i,
    output logic             data_ready_o,
    output logic [31:0]      bits_o,
    output logic [LEN_W-1:0] bits_avail_o,
    input  logic             consume_i,
    input  logic [4:0]       consume_len_i,
    input  logic             align_i,
    output logic             marker_valid_o,
    output logic [7:0]       marker_o,
    input  logic             marker_ack_i,
    output logic             consume_err_o
);

    logic [BUF_W-1:0] buf_q, buf_d, buf_a, buf_c;
    logic [LEN_W-1:0] len_q, len_d, len_a, len_c;
    logic [LEN_W-1:0] align_amt, cons_amt, cons_len;
    logic             cons_err, err_q;
    logic             room;
    logic             pend_valid;
    logic [7:0]       pend_byte;

    // Accept a new byte only while two more bytes (pending + in-flight) still fit
    assign room = (len_q <= LEN_W'(BUF_W - 16));

    bs_unstuffer u_unstuffer (
        .clk            (clk),
        .rst            (rst),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .marker_ack_i   (marker_ack_i),
        .room_i         (room),
        .data_ready_o   (data_ready_o),
        .pend_valid_o   (pend_valid),
        .pend_byte_o    (pend_byte),
        .marker_valid_o (marker_valid_o),
        .marker_o       (marker_o)
    );

    // Align, then validated consume, then merge of the pending byte at the new tail
    always_comb begin
        align_amt = align_i ? LEN_W'(len_q[2:0]) : '0;
        len_a     = len_q - align_amt;
        buf_a     = buf_q << align_amt;

        // Over-length or over-MAX_CONS requests are rejected; zero length is a no-op
        cons_len  = LEN_W'(consume_len_i);
        cons_err  = consume_i && (|consume_len_i) &&
                    ((cons_len > len_a) || (cons_len > LEN_W'(MAX_CONS)));
        cons_amt  = (consume_i && !cons_err) ? cons_len : '0;
        len_c     = len_a - cons_amt;
        buf_c     = buf_a << cons_amt;

        buf_d = buf_c;
        len_d = len_c;
        if (pend_valid) begin
            buf_d = buf_c | ({pend_byte, {(BUF_W - 8){1'b0}}} >> len_c);
            len_d = len_c + LEN_W'(8);
        end
    end

    // Bit buffer, fill level and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            len_q <= '0;
            err_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            len_q <= len_d;
            err_q <= cons_err;
        end
    end

    // The ready headroom rule must keep the buffer from ever overflowing
    assert property (@(posedge clk) disable iff (rst) len_q <= LEN_W'(BUF_W));

    assign bits_o        = buf_q[BUF_W-1 -: 32];
    assign bits_avail_o  = len_q;
    assign consume_err_o = err_q;

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed, table-driven bench for bitstream_reader with hand-computed vectors
// plus hand-written sequences for back-pressure and mid-stream reset.
module tb_bitstream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid_i;
    logic [7:0]  data_i;
    logic        data_ready_o;
    logic [31:0] bits_o;
    logic [6:0]  bits_avail_o;
    logic        consume_i;
    logic [4:0]  consume_len_i;
    logic        align_i;
    logic        marker_valid_o;
    logic [7:0]  marker_o;
    logic        marker_ack_i;
    logic        consume_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitstream_reader dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .data_ready_o   (data_ready_o),
        .bits_o         (bits_o),
        .bits_avail_o   (bits_avail_o),
        .consume_i      (consume_i),
        .consume_len_i  (consume_len_i),
        .align_i        (align_i),
        .marker_valid_o (marker_valid_o),
        .marker_o       (marker_o),
        .marker_ack_i   (marker_ack_i),
        .consume_err_o  (consume_err_o)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        cons;
        logic [4:0]  clen;
        logic        align;
        logic        ack;
        logic [6:0]  e_avail;
        logic [31:0] e_bits;
        logic        e_ready;
        logic        e_mv;
        logic [7:0]  e_marker;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic c,
                                input logic [4:0] cl, input logic al, input logic ak,
                                input logic [6:0] ea, input logic [31:0] eb,
                                input logic er, input logic emv, input logic [7:0] em,
                                input logic ee);
        vec_t r;
        r.valid = v; r.data = d; r.cons = c; r.clen = cl; r.align = al; r.ack = ak;
        r.e_avail = ea; r.e_bits = eb; r.e_ready = er; r.e_mv = emv;
        r.e_marker = em; r.e_err = ee;
        return r;
    endfunction

    task automatic idle_inputs();
        data_valid_i  = 1'b0;
        data_i        = 8'h00;
        consume_i     = 1'b0;
        consume_len_i = 5'd0;
        align_i       = 1'b0;
        marker_ack_i  = 1'b0;
    endtask

    // One clock with the current inputs; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_consume(input logic [4:0] n);
        idle_inputs();
        consume_i     = 1'b1;
        consume_len_i = n;
        tick();
        idle_inputs();
    endtask

    task automatic push_byte(input logic [7:0] b);
        idle_inputs();
        data_valid_i = 1'b1;
        data_i       = b;
        tick();
        idle_inputs();
    endtask

    initial begin
        int acc;
        int max_avail;
        logic [7:0] fill_b;

        //               v  data   c  len  al ak   avail  bits          rdy mv marker err
        vecs[0]  = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        vecs[1]  = mk(1, 8'h12, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        vecs[2]  = mk(1, 8'h34, 0, 5'd0,  0, 0, 7'd8,  32'h12000000, 1, 0, 8'h00, 0);
        vecs[3]  = mk(1, 8'h56, 0, 5'd0,  0, 0, 7'd16, 32'h12340000, 1, 0, 8'h00, 0);
        vecs[4]  = mk(1, 8'h78, 0, 5'd0,  0, 0, 7'd24, 32'h12345600, 1, 0, 8'h00, 0);
        vecs[5]  = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd32, 32'h12345678, 1, 0, 8'h00, 0);
        vecs[6]  = mk(0, 8'h00, 1, 5'd16, 0, 0, 7'd16, 32'h56780000, 1, 0, 8'h00, 0);
        vecs[7]  = mk(0, 8'h00, 1, 5'd16, 0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        // Stuffed FF00 inside data
        vecs[8]  = mk(1, 8'hAB, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        vecs[9]  = mk(1, 8'hFF, 0, 5'd0,  0, 0, 7'd8,  32'hAB000000, 1, 0, 8'h00, 0);
        vecs[10] = mk(1, 8'h00, 0, 5'd0,  0, 0, 7'd8,  32'hAB000000, 1, 0, 8'h00, 0);
        vecs[11] = mk(1, 8'hCD, 0, 5'd0,  0, 0, 7'd16, 32'hABFF0000, 1, 0, 8'h00, 0);
        vecs[12] = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd24, 32'hABFFCD00, 1, 0, 8'h00, 0);
        vecs[13] = mk(0, 8'h00, 1, 5'd16, 0, 0, 7'd8,  32'hCD000000, 1, 0, 8'h00, 0);
        vecs[14] = mk(0, 8'h00, 1, 5'd8,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        // Fill byte then EOI marker; buffered bits still consumable in MARKER
        vecs[15] = mk(1, 8'h5A, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'h00, 0);
        vecs[16] = mk(1, 8'hFF, 0, 5'd0,  0, 0, 7'd8,  32'h5A000000, 1, 0, 8'h00, 0);
        vecs[17] = mk(1, 8'hFF, 0, 5'd0,  0, 0, 7'd8,  32'h5A000000, 1, 0, 8'h00, 0);
        vecs[18] = mk(1, 8'hD9, 0, 5'd0,  0, 0, 7'd8,  32'h5A000000, 0, 1, 8'hD9, 0);
        vecs[19] = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd8,  32'h5A000000, 0, 1, 8'hD9, 0);
        vecs[20] = mk(0, 8'h00, 1, 5'd8,  0, 0, 7'd0,  32'h00000000, 0, 1, 8'hD9, 0);
        vecs[21] = mk(0, 8'h00, 0, 5'd0,  0, 1, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);
        // Consume concurrent with merge
        vecs[22] = mk(1, 8'hF0, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);
        vecs[23] = mk(1, 8'h0F, 0, 5'd0,  0, 0, 7'd8,  32'hF0000000, 1, 0, 8'hD9, 0);
        vecs[24] = mk(0, 8'h00, 1, 5'd3,  0, 0, 7'd13, 32'h80780000, 1, 0, 8'hD9, 0);
        // Over-length consume, then align
        vecs[25] = mk(0, 8'h00, 1, 5'd8,  0, 0, 7'd5,  32'h78000000, 1, 0, 8'hD9, 0);
        vecs[26] = mk(0, 8'h00, 1, 5'd9,  0, 0, 7'd5,  32'h78000000, 1, 0, 8'hD9, 1);
        vecs[27] = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd5,  32'h78000000, 1, 0, 8'hD9, 0);
        vecs[28] = mk(0, 8'h00, 0, 5'd0,  1, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);
        vecs[29] = mk(0, 8'h00, 1, 5'd1,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 1);
        vecs[30] = mk(0, 8'h00, 1, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);
        // Align and consume together: align first, consume checked after
        vecs[31] = mk(1, 8'hA5, 0, 5'd0,  0, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);
        vecs[32] = mk(1, 8'h3C, 0, 5'd0,  0, 0, 7'd8,  32'hA5000000, 1, 0, 8'hD9, 0);
        vecs[33] = mk(0, 8'h00, 0, 5'd0,  0, 0, 7'd16, 32'hA53C0000, 1, 0, 8'hD9, 0);
        vecs[34] = mk(0, 8'h00, 1, 5'd3,  0, 0, 7'd13, 32'h29E00000, 1, 0, 8'hD9, 0);
        vecs[35] = mk(0, 8'h00, 1, 5'd4,  1, 0, 7'd4,  32'hC0000000, 1, 0, 8'hD9, 0);
        vecs[36] = mk(0, 8'h00, 0, 5'd0,  1, 0, 7'd0,  32'h00000000, 1, 0, 8'hD9, 0);

        // Reset state, including data_ready held low during reset
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_avail",  32'(bits_avail_o),   32'd0);
        check("rst_bits",   bits_o,              32'h0);
        check("rst_ready",  32'(data_ready_o),   32'd0);
        check("rst_mv",     32'(marker_valid_o), 32'd0);
        check("rst_marker", 32'(marker_o),       32'h0);
        check("rst_err",    32'(consume_err_o),  32'd0);
        rst = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < NVEC; i++) begin
            data_valid_i  = vecs[i].valid;
            data_i        = vecs[i].data;
            consume_i     = vecs[i].cons;
            consume_len_i = vecs[i].clen;
            align_i       = vecs[i].align;
            marker_ack_i  = vecs[i].ack;
            tick();
            check($sformatf("v%0d_avail", i),  32'(bits_avail_o),   32'(vecs[i].e_avail));
            check($sformatf("v%0d_bits", i),   bits_o,              vecs[i].e_bits);
            check($sformatf("v%0d_ready", i),  32'(data_ready_o),   32'(vecs[i].e_ready));
            check($sformatf("v%0d_mv", i),     32'(marker_valid_o), 32'(vecs[i].e_mv));
            check($sformatf("v%0d_marker", i), 32'(marker_o),       32'(vecs[i].e_marker));
            check($sformatf("v%0d_err", i),    32'(consume_err_o),  32'(vecs[i].e_err));
        end
        idle_inputs();

        // Continuous input with no consume: back-pressure at 56, cap at 64
        acc       = 0;
        max_avail = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            fill_b       = 8'(8'h11 * (acc + 1));
            data_valid_i = 1'b1;
            data_i       = fill_b;
            if (data_ready_o) acc++;
            tick();
            if (int'(bits_avail_o) > max_avail) max_avail = int'(bits_avail_o);
            check("bp_ready_vs_avail", 32'(data_ready_o), 32'(bits_avail_o <= 7'd48));
        end
        idle_inputs();
        check("bp_accepted", 32'(acc),           32'd8);
        check("bp_max",      32'(max_avail),     32'd64);
        check("bp_avail",    32'(bits_avail_o),  32'd64);
        check("bp_ready",    32'(data_ready_o),  32'd0);
        check("bp_bits",     bits_o,             32'h11223344);
        do_consume(5'd16);
        check("bp_drain1_avail", 32'(bits_avail_o), 32'd48);
        check("bp_drain1_bits",  bits_o,            32'h33445566);
        check("bp_drain1_ready", 32'(data_ready_o), 32'd1);
        do_consume(5'd16);
        check("bp_drain2_avail", 32'(bits_avail_o), 32'd32);
        check("bp_drain2_bits",  bits_o,            32'h55667788);
        do_consume(5'd16);
        do_consume(5'd16);
        check("bp_drain4_avail", 32'(bits_avail_o), 32'd0);

        // Mid-stream reset in GOT_FF with data buffered
        push_byte(8'h77);
        push_byte(8'hFF);
        tick();
        check("mr_pre_avail", 32'(bits_avail_o), 32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_avail",  32'(bits_avail_o),   32'd0);
        check("mr_bits",   bits_o,              32'h0);
        check("mr_ready",  32'(data_ready_o),   32'd0);
        check("mr_mv",     32'(marker_valid_o), 32'd0);
        check("mr_marker", 32'(marker_o),       32'h0);
        check("mr_err",    32'(consume_err_o),  32'd0);
        tick();
        check("mr_ready_after", 32'(data_ready_o), 32'd1);
        // A 00 after reset must be plain data, not the tail of a stuffed FF
        push_byte(8'h00);
        tick();
        check("mr_zero_avail", 32'(bits_avail_o), 32'd8);
        check("mr_zero_bits",  bits_o,            32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
